// File: rtl/fft_peak_detect.sv
// fft_peak_detect: per-bin power stream from fft_256 output plus per-frame
// peak bin/power search with early-sop framing error detection.
module fft_peak_detect #(
  parameter int N       = 256,
  parameter int DW      = 16,
  parameter int IDXW    = 8,
  parameter bit SKIP_DC = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic                 sop_in,
  input  logic signed [DW-1:0] x_re,
  input  logic signed [DW-1:0] x_im,
  output logic                 pwr_valid,
  output logic                 pwr_sop,
  output logic [2*DW-1:0]      pwr,
  output logic                 peak_valid,
  output logic [IDXW-1:0]      peak_idx,
  output logic [2*DW-1:0]      peak_pwr,
  output logic                 frame_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);
  logic                   v1_q, s1_q, v2_q, s2_q;
  logic signed [2*DW-1:0] re_w, im_w, rr_q, ii_q;
  logic [2*DW-1:0]        pwr_q, max_q, max_d, ppwr_q, ppwr_d, nmax;
  logic [0:0]             st_q, st_d;
  logic [IDXW-1:0]        cnt_q, cnt_d, midx_q, midx_d, pidx_q, pidx_d, nidx;
  logic                   pv_q, pv_d, fe_q, fe_d, gt;
  assign re_w = (2*DW)'(x_re);
  assign im_w = (2*DW)'(x_im);
  // Both squares are non-negative, so the sum is taken unsigned to hold 2^31.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      s1_q  <= 1'b0;
      v2_q  <= 1'b0;
      s2_q  <= 1'b0;
      rr_q  <= '0;
      ii_q  <= '0;
      pwr_q <= '0;
    end else begin
      v1_q  <= valid_in;
      s1_q  <= valid_in & sop_in;
      v2_q  <= v1_q;
      s2_q  <= s1_q;
      rr_q  <= re_w * re_w;
      ii_q  <= im_w * im_w;
      pwr_q <= $unsigned(rr_q) + $unsigned(ii_q);
    end
  end
  assign gt   = pwr_q > max_q;
  assign nmax = gt ? pwr_q : max_q;
  assign nidx = gt ? cnt_q : midx_q;
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    max_d  = max_q;
    midx_d = midx_q;
    pidx_d = pidx_q;
    ppwr_d = ppwr_q;
    pv_d   = 1'b0;
    fe_d   = 1'b0;
    if (v2_q && s2_q) begin
      fe_d   = st_q == ACC;
      st_d   = ACC;
      cnt_d  = IDXW'(1);
      max_d  = SKIP_DC ? '0 : pwr_q;
      midx_d = '0;
    end else if (v2_q && st_q == ACC) begin
      cnt_d  = cnt_q + 1'b1;
      max_d  = nmax;
      midx_d = nidx;
      if (cnt_q == LAST) begin
        pidx_d = nidx;
        ppwr_d = nmax;
        pv_d   = 1'b1;
        st_d   = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      max_q  <= '0;
      midx_q <= '0;
      pidx_q <= '0;
      ppwr_q <= '0;
      pv_q   <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      max_q  <= max_d;
      midx_q <= midx_d;
      pidx_q <= pidx_d;
      ppwr_q <= ppwr_d;
      pv_q   <= pv_d;
      fe_q   <= fe_d;
    end
  end
  assign pwr_valid  = v2_q;
  assign pwr_sop    = s2_q;
  assign pwr        = pwr_q;
  assign peak_valid = pv_q;
  assign peak_idx   = pidx_q;
  assign peak_pwr   = ppwr_q;
  assign frame_err  = fe_q;
endmodule

// File: doc/fft_peak_detect.md
# fft_peak_detect

Streaming post-processor on the FFT output stream. It consumes the 256-bin frames produced by fft_256 (valid/sop plus 16-bit signed re/im) and forwards a per-bin power stream. For each complete frame it reports the bin with the largest power, that power, and a framing-error flag. The block sits directly downstream of fft_256 and feeds spectrum monitoring and detection logic.

## Interface
- N, 256: bins per frame; a power of two
- DW, 16: input sample width, signed two's complement
- IDXW, 8: bin index width; equals log2(N)
- SKIP_DC, 0: when 1, bin 0 is excluded from the peak search. Its power is still streamed.

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  input sample strobe; connects to fft_256 valid_out
- sop_in  in  1  start of frame; meaningful only with valid_in; connects to fft_256 sop_out
- x_re  in  DW  bin real part, signed
- x_im  in  DW  bin imaginary part, signed
- pwr_valid  out  1  power sample strobe
- pwr_sop  out  1  marks the power sample of bin 0
- pwr  out  2*DW  unsigned power, x_re^2 + x_im^2
- peak_valid  out  1  one-cycle pulse when a frame result is updated
- peak_idx  out  IDXW  bin index of the maximum power
- peak_pwr  out  2*DW  maximum power value
- frame_err  out  1  one-cycle pulse when a frame is aborted

## Operation
- **Power pipeline**
  - Stage 1 registers re*re and im*im as signed products (2*DW bits).
  - Stage 2 registers their unsigned sum into pwr.
  - Worst case: (-2^15)^2 * 2 = 2^31, which fits in 32 bits unsigned. No saturation or rounding.
  - Every valid_in sample produces a power sample, framed or not. valid and sop travel alongside the data.
- **Frame tracking**
  - Runs on the stage-2 (pwr) side, using the delayed sop.
  - FSM states: IDLE, ACC.
  - IDLE + pwr_valid & pwr_sop: load bin 0 as the current maximum (value 0 if SKIP_DC=1), set bin counter to 1, go to ACC.
  - IDLE + pwr_valid without sop: the sample is ignored for peak search.
  - ACC + pwr_valid & !pwr_sop: compare pwr against the running max and increment the bin counter.
  - Comparison is strictly greater. On ties the lowest index wins.
  - ACC, sample with counter = N-1: after comparison, latch peak_idx/peak_pwr, pulse peak_valid, go to IDLE.
  - ACC + pwr_valid & pwr_sop (early sop): pulse frame_err and leave peak outputs unchanged. The sop sample starts a new frame as bin 0 and the FSM stays in ACC.
  - ACC gaps (valid low) are allowed and unbounded. The counter and max hold.
- **Output holding**
  - peak_idx/peak_pwr hold until the next completed frame.
  - If every bin has power 0 (or all non-DC bins with SKIP_DC=1), the result is idx 0, pwr 0.

## Timing
- pwr_valid/pwr_sop/pwr appear 2 cycles after the corresponding valid_in/sop_in.
- peak_valid, peak_idx and peak_pwr update 1 cycle after pwr_valid of bin N-1, i.e. 3 cycles after bin N-1 at the input.
- frame_err pulses 1 cycle after the offending pwr_sop, i.e. 3 cycles after sop_in.
- Back-to-back frames are supported: sop may arrive the cycle after bin N-1 with no bubble. The result of frame k and bin 0 of frame k+1 are processed in the same cycle without interference.
- Reset (async, any time, including mid-frame):
  - All outputs go to 0, the pipeline is flushed, the FSM goes to IDLE, the counter and max go to 0.
  - The first frame result after reset requires a fresh sop.
- sop_in without valid_in is ignored.

## Test plan
- **Single tone:** a 256-bin frame, all bins 0 except bin 37 = (1000, -2000). Required: pwr for bin 37 = 5,000,000; peak_valid 3 cycles after bin 255; peak_idx 37; peak_pwr 5,000,000.
- **Full scale and tie:** bins 10 and 200 both (-32768, -32768), others 0. Required: pwr 0x8000_0000 for both; peak_idx 10 (lowest index on tie).
- **Early sop:** sop at the start of a frame, then a new sop after bin 99. Required: frame_err pulse 3 cycles after the second sop; no peak_valid for the aborted frame; the next 256 bins yield a normal result.
- **SKIP_DC:** with SKIP_DC=1, bin 0 = (30000, 0) and bin 5 = (100, 0). Required: peak_idx 5, peak_pwr 10,000, and pwr stream bin 0 = 900,000,000. With SKIP_DC=0: peak_idx 0.
- **Gaps and back-to-back:** valid_in is randomly deasserted about 30% of cycles within frame 1, and frame 2 follows immediately after bin 255. Required: both results correct; the frame-2 result equals its bin-128 tone.
- **Reset mid-frame:** rst_n asserted at bin 150. Required: all outputs 0 immediately. Unframed samples after reset produce pwr but no peak_valid until a new sop plus 256 bins.
